// File: rtl/iob_out_cfg_pkg.sv
// rtl/iob_out_cfg_pkg.sv - configuration word layout and TSMUX encodings for iob_out_cfg
package iob_out_cfg_pkg;

  localparam int CFG_W     = 8;
  localparam int TSMUX_LSB = 0;
  localparam int OREG_BIT  = 2;
  localparam int TREG_BIT  = 3;
  localparam int OINV_BIT  = 4;
  localparam int OINIT_BIT = 5;
  localparam int RSVD_LSB  = 6;
  localparam int RSVD_MSB  = 7;

  typedef enum logic [1:0] {
    TS_OFF = 2'b00,
    TS_HI  = 2'b01,
    TS_LO  = 2'b10,
    TS_ON  = 2'b11
  } tsmux_e;

endpackage

// File: rtl/iob_out_cfg_chain.sv
// rtl/iob_out_cfg_chain.sv - serial config shift chain with commit check and done/err pulses
module iob_cfg_chain
  import iob_out_cfg_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_din,
  input  logic             i_load,
  output logic             o_commit,
  output logic [CFG_W-1:0] o_word,
  output logic             o_done,
  output logic             o_err
);

  logic [CFG_W-1:0] r_shadow;
  logic [3:0]       r_cnt;
  logic             r_done;
  logic             r_err;
  logic             w_commit;
  logic             w_reject;

  // A load during a shift is always rejected; the shift still takes effect.
  assign w_commit = i_load && !i_en && (r_cnt == 4'd8) &&
                    (r_shadow[RSVD_MSB:RSVD_LSB] == '0);
  assign w_reject = i_load && !w_commit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (i_en) begin
        r_shadow <= {r_shadow[CFG_W-2:0], i_din};
        r_cnt    <= (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
      end else if (i_load) begin
        r_cnt <= '0;
      end
      r_done <= w_commit;
      r_err  <= w_reject;
    end
  end

  assign o_commit = w_commit;
  assign o_word   = r_shadow;
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule

// File: rtl/iob_out_cfg.sv
// rtl/iob_out_cfg.sv - pad output/OE driver with optional O/T registers and committed serial config
module iob_out_cfg
  import iob_out_cfg_pkg::*;
#(
  parameter logic [7:0] CFG_RESET = 8'h00
) (
  input  logic             IOCLK,
  input  logic             RST,
  input  logic             OUT,
  input  logic             TS,
  input  logic             OCE,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  input  logic             CFG_LOAD,
  output logic             CFG_DONE,
  output logic             CFG_ERR,
  output logic [CFG_W-1:0] CFG_Q,
  output logic             PAD_O,
  output logic             PAD_OE
);

  logic [CFG_W-1:0] r_active;
  logic             r_oq;
  logic             r_tq;
  logic             w_commit;
  logic [CFG_W-1:0] w_word;
  logic             w_odata;
  logic             w_ts_eff;
  logic             w_oe;

  iob_cfg_chain u_chain (
    .i_clk    (IOCLK),
    .i_rst    (RST),
    .i_en     (CFG_EN),
    .i_din    (CFG_DIN),
    .i_load   (CFG_LOAD),
    .o_commit (w_commit),
    .o_word   (w_word),
    .o_done   (CFG_DONE),
    .o_err    (CFG_ERR)
  );

  assign w_odata = OUT ^ r_active[OINV_BIT];

  // A commit reinitialises the data registers regardless of OCE.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      r_active <= CFG_RESET;
      r_oq     <= CFG_RESET[OINIT_BIT];
      r_tq     <= 1'b0;
    end else if (w_commit) begin
      r_active <= w_word;
      r_oq     <= w_word[OINIT_BIT];
      r_tq     <= 1'b0;
    end else if (OCE) begin
      r_oq <= w_odata;
      r_tq <= TS;
    end
  end

  assign w_ts_eff = r_active[TREG_BIT] ? r_tq : TS;

  always_comb begin
    w_oe = 1'b0;
    case (r_active[TSMUX_LSB+1:TSMUX_LSB])
      TS_OFF:  w_oe = 1'b0;
      TS_HI:   w_oe = w_ts_eff;
      TS_LO:   w_oe = !w_ts_eff;
      TS_ON:   w_oe = 1'b1;
      default: w_oe = 1'b0;
    endcase
  end

  assign PAD_O  = r_active[OREG_BIT] ? r_oq : w_odata;
  assign PAD_OE = w_oe;
  assign CFG_Q  = r_active;

endmodule

// File: tb/tb_iob_out_cfg.sv
// tb/tb_iob_out_cfg.sv - directed table and sequence bench for iob_out_cfg
module tb_iob_out_cfg;

  logic       IOCLK = 1'b0;
  logic       RST = 1'b1;
  logic       OUT = 1'b0;
  logic       TS = 1'b0;
  logic       OCE = 1'b0;
  logic       CFG_EN = 1'b0;
  logic       CFG_DIN = 1'b0;
  logic       CFG_LOAD = 1'b0;
  logic       CFG_DONE;
  logic       CFG_ERR;
  logic [7:0] CFG_Q;
  logic       PAD_O;
  logic       PAD_OE;

  int n_pass = 0;
  int n_total = 0;

  iob_out_cfg #(.CFG_RESET(8'h00)) dut (
    .IOCLK    (IOCLK),
    .RST      (RST),
    .OUT      (OUT),
    .TS       (TS),
    .OCE      (OCE),
    .CFG_EN   (CFG_EN),
    .CFG_DIN  (CFG_DIN),
    .CFG_LOAD (CFG_LOAD),
    .CFG_DONE (CFG_DONE),
    .CFG_ERR  (CFG_ERR),
    .CFG_Q    (CFG_Q),
    .PAD_O    (PAD_O),
    .PAD_OE   (PAD_OE)
  );

  always #5 IOCLK = ~IOCLK;

  typedef struct {
    logic [7:0] cfg;
    logic       out;
    logic       ts;
    logic       exp_o;
    logic       exp_oe;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge IOCLK);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      CFG_EN  = 1'b1;
      CFG_DIN = v[i];
      step();
    end
    CFG_EN  = 1'b0;
    CFG_DIN = 1'b0;
  endtask

  task automatic commit();
    CFG_LOAD = 1'b1;
    step();
    CFG_LOAD = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h0F, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h12, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h1B, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h0A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h25, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    step();
    step();
    RST = 1'b0;
    #1;
    chk("rst_oe", {7'd0, PAD_OE}, 8'h00);
    chk("rst_o", {7'd0, PAD_O}, 8'h00);
    chk("rst_q", CFG_Q, 8'h00);
    chk("rst_done", {7'd0, CFG_DONE}, 8'h00);
    chk("rst_err", {7'd0, CFG_ERR}, 8'h00);
    step();
    chk("rst_q_hold", CFG_Q, 8'h00);

    // Table: commit each word, then one enabled edge with held inputs
    foreach (vecs[k]) begin
      shift_bits({8'h00, vecs[k].cfg}, 8);
      commit();
      chk($sformatf("v%0d_done", k), {7'd0, CFG_DONE}, 8'h01);
      chk($sformatf("v%0d_q", k), CFG_Q, vecs[k].cfg);
      OUT = vecs[k].out;
      TS  = vecs[k].ts;
      OCE = 1'b1;
      step();
      OCE = 1'b0;
      #1;
      chk($sformatf("v%0d_o", k), {7'd0, PAD_O}, {7'd0, vecs[k].exp_o});
      chk($sformatf("v%0d_oe", k), {7'd0, PAD_OE}, {7'd0, vecs[k].exp_oe});
      chk($sformatf("v%0d_done_clr", k), {7'd0, CFG_DONE}, 8'h00);
    end

    // Registered output latency (OREG) with 0F
    OUT = 1'b0; TS = 1'b0;
    shift_bits(16'h000F, 8);
    commit();
    chk("lat_o_init", {7'd0, PAD_O}, 8'h00);
    OCE = 1'b1;
    OUT = 1'b1;
    #1;
    chk("lat_o_before", {7'd0, PAD_O}, 8'h00);
    step();
    chk("lat_o_after", {7'd0, PAD_O}, 8'h01);
    OCE = 1'b0;

    // Registered tristate latency (TREG, TSMUX=01) with 0D
    TS = 1'b0;
    shift_bits(16'h000D, 8);
    commit();
    chk("lat_t_init", {7'd0, PAD_OE}, 8'h00);
    OCE = 1'b1;
    TS = 1'b1;
    #1;
    chk("lat_t_before", {7'd0, PAD_OE}, 8'h00);
    step();
    chk("lat_t_after", {7'd0, PAD_OE}, 8'h01);
    OCE = 1'b0;

    // Back-to-back load without fresh shifts is rejected
    commit();
    chk("b2b_err", {7'd0, CFG_ERR}, 8'h01);
    chk("b2b_q", CFG_Q, 8'h0D);

    // Rejected commits: 7 bits, 9 bits, reserved bit
    shift_bits(16'h0003, 7);
    commit();
    chk("short_err", {7'd0, CFG_ERR}, 8'h01);
    chk("short_done", {7'd0, CFG_DONE}, 8'h00);
    chk("short_q", CFG_Q, 8'h0D);
    step();
    chk("short_err_clr", {7'd0, CFG_ERR}, 8'h00);
    shift_bits(16'h0003, 9);
    commit();
    chk("long_err", {7'd0, CFG_ERR}, 8'h01);
    chk("long_q", CFG_Q, 8'h0D);
    shift_bits(16'h0040, 8);
    commit();
    chk("rsvd_err", {7'd0, CFG_ERR}, 8'h01);
    chk("rsvd_q", CFG_Q, 8'h0D);

    // OREG with OINIT and OCE held low
    OUT = 1'b0;
    shift_bits(16'h0027, 8);
    commit();
    chk("oinit_done", {7'd0, CFG_DONE}, 8'h01);
    chk("oinit_o", {7'd0, PAD_O}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      OUT = ~OUT;
      step();
      chk($sformatf("oinit_hold%0d", i), {7'd0, PAD_O}, 8'h01);
    end

    // Async reset during the 5th shift bit
    shift_bits(16'h000F, 4);
    CFG_EN = 1'b1;
    CFG_DIN = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    chk("arst_q", CFG_Q, 8'h00);
    chk("arst_oe", {7'd0, PAD_OE}, 8'h00);
    chk("arst_o", {7'd0, PAD_O}, {7'd0, OUT});
    CFG_EN = 1'b0;
    step();
    RST = 1'b0;
    #1;
    shift_bits(16'h0003, 8);
    commit();
    chk("arst_re_done", {7'd0, CFG_DONE}, 8'h01);
    chk("arst_re_q", CFG_Q, 8'h03);
    chk("arst_re_oe", {7'd0, PAD_OE}, 8'h01);

    // EN and LOAD together on the 8th bit
    shift_bits(16'h0007, 7);
    CFG_EN = 1'b1;
    CFG_DIN = 1'b1;
    CFG_LOAD = 1'b1;
    step();
    CFG_EN = 1'b0;
    CFG_LOAD = 1'b0;
    #1;
    chk("both_err", {7'd0, CFG_ERR}, 8'h01);
    chk("both_done", {7'd0, CFG_DONE}, 8'h00);
    chk("both_q", CFG_Q, 8'h03);
    // count was not cleared, so a plain load now commits the 8 bits
    commit();
    chk("both_after_done", {7'd0, CFG_DONE}, 8'h01);
    chk("both_after_q", CFG_Q, 8'h0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
